// File: rtl/unstripe_lane_sched.sv
// Two-lane unstripe scheduler: alternates lane FIFO pops, gates start-up
// on lane fill levels and flags persistent lane underrun as skew.
module unstripe_lane_sched #(
   parameter int START_THRESH = 2,
   parameter int TIMEOUT      = 15,
   parameter int CNT_W        = 4
) (
   input  logic             clk_f,
   input  logic             reset,
   input  logic             enable,
   input  logic             out_ready,
   input  logic             empty_0,
   input  logic             empty_1,
   input  logic [CNT_W-1:0] level_0,
   input  logic [CNT_W-1:0] level_1,
   output logic             pop_0,
   output logic             pop_1,
   output logic             sel,
   output logic             valid_unstripe_out,
   output logic [1:0]       state_out,
   output logic             skew_err,
   output logic [7:0]       underrun_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RUN,
      S_DRAIN,
      S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             sel_d, valid_d, skew_d;
   logic [7:0]       cnt_d;
   logic             active, empty_ptr, underrun, timeout, pop, lvl_ok;

   always_ff @(posedge clk_f) begin
      if (reset) begin
         state_q            <= S_IDLE;
         ptr_q              <= 1'b0;
         stall_q            <= '0;
         sel                <= 1'b0;
         valid_unstripe_out <= 1'b0;
         skew_err           <= 1'b0;
         underrun_cnt       <= 8'd0;
      end else begin
         state_q            <= state_d;
         ptr_q              <= ptr_d;
         stall_q            <= stall_d;
         sel                <= sel_d;
         valid_unstripe_out <= valid_d;
         skew_err           <= skew_d;
         underrun_cnt       <= cnt_d;
      end
   end

   always_comb begin
      active    = (state_q == S_RUN) || (state_q == S_DRAIN);
      empty_ptr = ptr_q ? empty_1 : empty_0;
      underrun  = active & out_ready & empty_ptr;
      timeout   = underrun && (stall_q == CNT_W'(TIMEOUT - 1));
      lvl_ok    = (level_0 >= CNT_W'(START_THRESH))
               && (level_1 >= CNT_W'(START_THRESH));
      // enable=0 in RUN outranks a pop; DRAIN finishes the pair regardless
      pop       = active & out_ready & ~empty_ptr & ~reset
               & ((state_q == S_DRAIN) | enable);

      state_d = state_q;
      ptr_d   = ptr_q;
      stall_d = stall_q;
      sel_d   = sel;
      valid_d = pop;
      skew_d  = skew_err;
      cnt_d   = underrun_cnt;

      if (underrun) begin
         stall_d = stall_q + 1'b1;
         if (underrun_cnt != 8'hFF) cnt_d = underrun_cnt + 8'd1;
      end
      if (pop) begin
         ptr_d   = ~ptr_q;
         stall_d = '0;
         sel_d   = ptr_q;
      end

      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (lvl_ok) begin
               state_d = S_RUN;
               ptr_d   = 1'b0;
               stall_d = '0;
            end
         end
         S_RUN: begin
            if (timeout) begin
               state_d = S_ERROR;
               skew_d  = 1'b1;
            end else if (!enable) begin
               state_d = ptr_q ? S_DRAIN : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (timeout) begin
               state_d = S_ERROR;
               skew_d  = 1'b1;
            end else if (pop) begin
               state_d = S_IDLE;
            end
         end
         S_ERROR: begin
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pop_0 = pop & ~ptr_q;
   assign pop_1 = pop & ptr_q;

   always_comb begin
      unique case (state_q)
         S_IDLE:  state_out = 2'd0;
         S_WAIT:  state_out = 2'd1;
         S_ERROR: state_out = 2'd3;
         default: state_out = 2'd2;
      endcase
   end

endmodule

// File: tb/tb_unstripe_lane_sched.sv
// Bench for unstripe_lane_sched: lane FIFO fill model, behavioural
// scheduler model and a scoreboard of expected lane selects.
module tb_unstripe_lane_sched;

   localparam int TO  = 15;
   localparam int THR = 2;

   logic       clk_f = 1'b0;
   logic       reset, enable, out_ready, empty_0, empty_1;
   logic [3:0] level_0, level_1;
   logic       pop_0, pop_1, sel, valid_unstripe_out, skew_err;
   logic [1:0] state_out;
   logic [7:0] underrun_cnt;

   unstripe_lane_sched dut (
      .clk_f(clk_f), .reset(reset), .enable(enable),
      .out_ready(out_ready), .empty_0(empty_0), .empty_1(empty_1),
      .level_0(level_0), .level_1(level_1),
      .pop_0(pop_0), .pop_1(pop_1), .sel(sel),
      .valid_unstripe_out(valid_unstripe_out),
      .state_out(state_out), .skew_err(skew_err),
      .underrun_cnt(underrun_cnt)
   );

   always #5 clk_f = ~clk_f;

   int checks = 0;
   int errors = 0;
   int cnt0 = 0, cnt1 = 0;
   int sb[$];

   // model: 0 idle, 1 wait, 2 run, 3 drain, 4 error
   int m_mode, m_lane, m_stall, m_under, m_sel, m_valid, m_skew;
   bit starve, take, x_pop0, x_pop1;

   task automatic chk(string n, int a, int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, a, e);
      end
   endtask

   function automatic int exp_state();
      case (m_mode)
         0: return 0;
         1: return 1;
         4: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic void model_comb();
      bit busy;
      busy   = (m_mode == 2) || (m_mode == 3);
      starve = busy && out_ready && (m_lane == 1 ? empty_1 : empty_0);
      take   = !reset && busy && out_ready && !starve
            && (m_mode == 3 || enable);
      x_pop0 = take && m_lane == 0;
      x_pop1 = take && m_lane == 1;
   endfunction

   function automatic void model_seq();
      if (reset) begin
         m_mode = 0; m_lane = 0; m_stall = 0; m_under = 0;
         m_sel = 0; m_valid = 0; m_skew = 0;
         return;
      end
      m_valid = take;
      if (take) m_sel = m_lane;
      if (starve) begin
         m_stall++;
         if (m_under < 255) m_under++;
      end
      if (take) begin
         m_lane = 1 - m_lane;
         m_stall = 0;
      end
      case (m_mode)
         0: if (enable) m_mode = 1;
         1: if (!enable) m_mode = 0;
            else if (level_0 >= THR && level_1 >= THR) begin
               m_mode = 2; m_lane = 0; m_stall = 0;
            end
         2, 3: if (starve && m_stall == TO) begin
               m_mode = 4; m_skew = 1;
            end else if (m_mode == 2 && !enable) begin
               m_mode = (m_lane == 1) ? 3 : 0;
            end else if (m_mode == 3 && take) begin
               m_mode = 0;
            end
         default: if (!enable) m_mode = 0;
      endcase
   endfunction

   task automatic cyc();
      level_0 = 4'(cnt0);
      level_1 = 4'(cnt1);
      empty_0 = (cnt0 == 0);
      empty_1 = (cnt1 == 0);
      @(negedge clk_f);
      model_comb();
      chk("pop_0", pop_0, x_pop0);
      chk("pop_1", pop_1, x_pop1);
      chk("state_out", state_out, exp_state());
      chk("valid", valid_unstripe_out, m_valid);
      chk("sel", sel, m_sel);
      chk("skew_err", skew_err, m_skew);
      chk("underrun_cnt", underrun_cnt, m_under);
      if (take) sb.push_back(m_lane);
      @(posedge clk_f);
      model_seq();
      if (x_pop0 && cnt0 > 0) cnt0--;
      if (x_pop1 && cnt1 > 0) cnt1--;
      #1;
   endtask

   task automatic run_n(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // output byte stream monitor
   initial begin
      forever begin
         @(negedge clk_f);
         if (valid_unstripe_out === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected", 1, 0);
            end else begin
               chk("sb_sel", sel, sb.pop_front());
            end
         end
      end
   end

   initial begin
      bit hit;
      reset = 1; enable = 0; out_ready = 0;
      empty_0 = 1; empty_1 = 1; level_0 = 0; level_1 = 0;
      take = 0; starve = 0;
      @(posedge clk_f);
      model_seq();
      #1;
      run_n(2);
      reset = 0;

      // start-up gate, then alternating pops
      enable = 1; out_ready = 1; cnt0 = 2; cnt1 = 1;
      run_n(4);
      cnt1 = 2;
      run_n(7);

      // lane-1 underrun for three cycles, then recovery
      cnt0 = 1;
      run_n(4);
      cnt1 = 3;
      run_n(2);

      // backpressure never times out; underrun does
      cnt0 = 0; out_ready = 0;
      run_n(20);
      out_ready = 1;
      run_n(16);
      chk("skew_set", skew_err, 1);
      enable = 0;
      run_n(2);
      chk("skew_sticky", skew_err, 1);

      // enable drop with ptr=1 drains lane 1
      enable = 1; cnt0 = 4; cnt1 = 4;
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         cyc();
         hit = (m_mode == 2 && m_lane == 1);
      end
      chk("bound_run_ptr1", hit, 1);
      enable = 0;
      run_n(4);

      // enable drop with ptr=0 goes straight to idle
      enable = 1; hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         cyc();
         hit = (m_mode == 2 && m_lane == 0);
      end
      chk("bound_run_ptr0", hit, 1);
      enable = 0;
      run_n(3);

      // repeated timeouts drive underrun_cnt into saturation
      for (int s = 0; s < 24; s++) begin
         enable = 1; out_ready = 1; cnt0 = 2; cnt1 = 2;
         hit = 0;
         for (int i = 0; i < 40 && !hit; i++) begin
            cyc();
            hit = (m_mode == 4);
         end
         chk("bound_err", hit, 1);
         enable = 0;
         cyc();
      end
      chk("sat_255", underrun_cnt, 255);

      // randomized traffic
      reset = 1; cyc(); reset = 0;
      cnt0 = 0; cnt1 = 0; enable = 1;
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         out_ready = ($urandom_range(0, 3) != 0);
         if (cnt0 < 15 && $urandom_range(0, 2) != 0) cnt0++;
         if (cnt1 < 15 && $urandom_range(0, 3) > 1) cnt1++;
         cyc();
      end

      reset = 0; enable = 0; out_ready = 0;
      run_n(5);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
